// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter sharing one combinational datapath between two requesters
module alu_arb #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] a_op1,
  input  logic [DW-1:0] a_op2,
  input  logic [1:0]    a_sel,
  output logic          a_rsp_valid,
  input  logic          a_rsp_ready,
  output logic [DW:0]   a_rsp_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [DW-1:0] b_op1,
  input  logic [DW-1:0] b_op2,
  input  logic [1:0]    b_sel,
  output logic          b_rsp_valid,
  input  logic          b_rsp_ready,
  output logic [DW:0]   b_rsp_data,
  output logic [DW-1:0] dp_op1,
  output logic [DW-1:0] dp_op2,
  output logic [1:0]    dp_sel,
  input  logic [DW:0]   dp_res,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic owner;
  logic last;
  logic grant_a;
  logic grant_b;
  logic rsp_done;
  assign grant_a  = (state == IDLE) && a_valid && (!b_valid || last);
  assign grant_b  = (state == IDLE) && b_valid && !grant_a;
  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign busy     = state != IDLE;
  assign rsp_done = (state == RESP) && (owner ? b_rsp_ready : a_rsp_ready);
  // IDLE latches the granted operands, EXEC captures the result, RESP waits for the owner
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_data  <= '0;
      dp_op1      <= '0;
      dp_op2      <= '0;
      dp_sel      <= '0;
    end else begin
      case (state)
        IDLE: if (grant_a || grant_b) begin
          state  <= EXEC;
          owner  <= grant_b;
          dp_op1 <= grant_b ? b_op1 : a_op1;
          dp_op2 <= grant_b ? b_op2 : a_op2;
          dp_sel <= grant_b ? b_sel : a_sel;
        end
        EXEC: begin
          state <= RESP;
          if (owner) begin
            b_rsp_data  <= dp_res;
            b_rsp_valid <= 1'b1;
          end else begin
            a_rsp_data  <= dp_res;
            a_rsp_valid <= 1'b1;
          end
        end
        RESP: if (rsp_done) begin
          state       <= IDLE;
          last        <= owner;
          a_rsp_valid <= 1'b0;
          b_rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: table vectors plus scoreboard and corner-case sequences for alu_arb
module tb_alu_arb;
  logic       clk = 0;
  logic       rst = 1;
  logic       a_valid = 0, b_valid = 0;
  logic       a_ready, b_ready;
  logic [7:0] a_op1 = 0, a_op2 = 0, b_op1 = 0, b_op2 = 0;
  logic [1:0] a_sel = 0, b_sel = 0;
  logic       a_rsp_valid, b_rsp_valid;
  logic       a_rsp_ready = 1, b_rsp_ready = 1;
  logic [8:0] a_rsp_data, b_rsp_data;
  logic [7:0] dp_op1, dp_op2;
  logic [1:0] dp_sel;
  logic [8:0] dp_res;
  logic       busy;
  int checks = 0, errors = 0;
  int a_done = 0, b_done = 0;
  logic [9:0] exp_q[$];
  logic       glog[$];
  typedef struct {
    logic       av, bv;
    logic [7:0] a1, a2, b1, b2;
    logic       first_b;
    logic [8:0] ea, eb;
  } vec_t;
  vec_t vt[7];

  alu_arb #(.DW(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2), .a_sel(a_sel),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2), .b_sel(b_sel),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
    .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_sel(dp_sel), .dp_res(dp_res), .busy(busy)
  );

  assign dp_res = {1'b0, dp_op1} + {1'b0, dp_op2};
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input logic who, input logic [8:0] data);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_rsp", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_owner", {31'd0, who}, {31'd0, e[9]});
      chk("sb_data", {23'd0, data}, {23'd0, e[8:0]});
    end
  endtask

  // scoreboard: expected sums pushed on accept, compared on response handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("one_hot_ready", {31'd0, a_ready && b_ready}, 0);
      if (a_ready) begin
        exp_q.push_back({1'b0, {1'b0, a_op1} + {1'b0, a_op2}});
        glog.push_back(1'b0);
      end
      if (b_ready) begin
        exp_q.push_back({1'b1, {1'b0, b_op1} + {1'b0, b_op2}});
        glog.push_back(1'b1);
      end
      if (a_rsp_valid && a_rsp_ready) begin
        pop_chk(1'b0, a_rsp_data);
        a_done++;
      end
      if (b_rsp_valid && b_rsp_ready) begin
        pop_chk(1'b1, b_rsp_data);
        b_done++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {30'd0, a_ready, b_ready}, 0);
    chk("rst_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 0);
    chk("rst_rsp_data", {14'd0, a_rsp_data, b_rsp_data}, 0);
    chk("rst_dp", {14'd0, dp_op1, dp_op2, dp_sel}, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    @(negedge clk);
    chk_reset();
    step();
    rst = 0;
    exp_q.delete();
  endtask

  task automatic wait_done(input string name, input int ad, input int bd);
    int n;
    n = 0;
    while ((a_done != ad || b_done != bd) && n < 40) begin
      step();
      n++;
    end
    chk(name, {31'd0, a_done == ad && b_done == bd}, 1);
  endtask

  initial begin
    int ad0, bd0, g0;
    logic a_acc, b_acc;
    vt[0] = '{1, 1, 8'h01, 8'h02, 8'h03, 8'h04, 0, 9'h003, 9'h007};
    vt[1] = '{1, 1, 8'h10, 8'h20, 8'h30, 8'h40, 0, 9'h030, 9'h070};
    vt[2] = '{1, 1, 8'h80, 8'h80, 8'hFF, 8'h01, 0, 9'h100, 9'h100};
    vt[3] = '{0, 1, 8'h00, 8'h00, 8'hFF, 8'hFF, 1, 9'h100, 9'h1FE};
    vt[4] = '{1, 1, 8'h7F, 8'h01, 8'h00, 8'h05, 0, 9'h080, 9'h005};
    vt[5] = '{1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 9'h000, 9'h005};
    vt[6] = '{1, 1, 8'h01, 8'h01, 8'h02, 8'h02, 1, 9'h002, 9'h004};
    #1;
    do_reset();
    // A alone, latency N / N+1 / N+2
    a_valid = 1; a_op1 = 8'hFF; a_op2 = 8'hFF; a_sel = 2'b00;
    @(negedge clk);
    chk("lat_a_ready_N", {30'd0, a_ready, b_ready}, 2);
    chk("lat_busy_N", {31'd0, busy}, 0);
    step();
    a_valid = 0;
    @(negedge clk);
    chk("lat_dp_N1", {16'd0, dp_op1, dp_op2}, 32'hFFFF);
    chk("lat_busy_N1", {31'd0, busy}, 1);
    chk("lat_no_rsp_N1", {31'd0, a_rsp_valid}, 0);
    step();
    @(negedge clk);
    chk("lat_rsp_N2", {22'd0, a_rsp_valid, a_rsp_data}, {22'd0, 1'b1, 9'h1FE});
    step();
    @(negedge clk);
    chk("lat_idle_after", {30'd0, busy, a_rsp_valid}, 0);
    chk("lat_done", a_done, 1);
    // table: simultaneous and mixed requests after a fresh reset
    do_reset();
    glog.delete();
    for (int i = 0; i < 7; i++) begin
      ad0 = a_done + int'(vt[i].av);
      bd0 = b_done + int'(vt[i].bv);
      g0 = glog.size();
      a_acc = 0; b_acc = 0;
      a_op1 = vt[i].a1; a_op2 = vt[i].a2; b_op1 = vt[i].b1; b_op2 = vt[i].b2;
      a_valid = vt[i].av; b_valid = vt[i].bv;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        a_acc |= a_ready;
        b_acc |= b_ready;
        step();
        if (a_acc) a_valid = 0;
        if (b_acc) b_valid = 0;
        if (a_done == ad0 && b_done == bd0) break;
      end
      chk($sformatf("vec%0d_complete", i), {31'd0, a_done == ad0 && b_done == bd0}, 1);
      chk($sformatf("vec%0d_ngrants", i), glog.size() - g0, int'(vt[i].av) + int'(vt[i].bv));
      if (glog.size() > g0) chk($sformatf("vec%0d_first", i), {31'd0, glog[g0]}, {31'd0, vt[i].first_b});
      chk($sformatf("vec%0d_a_data", i), {23'd0, a_rsp_data}, {23'd0, vt[i].ea});
      chk($sformatf("vec%0d_b_data", i), {23'd0, b_rsp_data}, {23'd0, vt[i].eb});
    end
    for (int i = 0; i < 6 && i < glog.size(); i++) chk($sformatf("rr_grant%0d", i), {31'd0, glog[i]}, i % 2);
    // backpressure on A with wrong-owner ready and B stalled
    ad0 = a_done; bd0 = b_done;
    a_rsp_ready = 0; b_rsp_ready = 1;
    a_valid = 1; a_op1 = 8'h11; a_op2 = 8'h22;
    @(negedge clk);
    chk("bp_a_ready", {31'd0, a_ready}, 1);
    step();
    a_valid = 0; b_valid = 1; b_op1 = 8'h05; b_op2 = 8'h06;
    @(negedge clk);
    chk("bp_exec_b_ready", {31'd0, b_ready}, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", {20'd0, a_rsp_valid, a_rsp_data, busy, b_ready}, {20'd0, 1'b1, 9'h033, 1'b1, 1'b0});
      chk("bp_b_rsp_valid", {31'd0, b_rsp_valid}, 0);
      step();
    end
    a_rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, a_rsp_valid}, 1);
    step();
    @(negedge clk);
    chk("bp_idle_next", {29'd0, busy, b_ready, a_rsp_valid}, 2);
    step();
    b_valid = 0;
    wait_done("bp_complete", ad0 + 1, bd0 + 1);
    chk("bp_b_data", {23'd0, b_rsp_data}, 32'h00B);
    // reset during EXEC aborts A, then B runs normally
    ad0 = a_done; bd0 = b_done;
    a_valid = 1; a_op1 = 8'h33; a_op2 = 8'h44;
    @(negedge clk);
    chk("rx_a_ready", {31'd0, a_ready}, 1);
    step();
    a_valid = 0;
    rst = 1;
    exp_q.delete();
    step();
    @(negedge clk);
    chk_reset();
    step();
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rx_no_rsp", {29'd0, a_rsp_valid, b_rsp_valid, busy}, 0);
      step();
    end
    b_valid = 1; b_op1 = 8'h09; b_op2 = 8'h0A;
    @(negedge clk);
    chk("rx_b_ready", {31'd0, b_ready}, 1);
    step();
    b_valid = 0;
    wait_done("rx_b_complete", ad0, bd0 + 1);
    chk("rx_b_data", {23'd0, b_rsp_data}, 32'h013);
    chk("rx_a_data", {23'd0, a_rsp_data}, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: DW, 8, operand width; result width is DW+1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a_valid  input  1  requester A has an operation pending.
REQ-005 a_ready  output  1  A's operation is accepted this cycle.
REQ-006 a_op1, a_op2  input  DW  A operands; a_sel  input  2  A operation select.
REQ-007 a_rsp_valid  output  1  A result available; a_rsp_ready  input  1  A consumes result.
REQ-008 a_rsp_data  output  DW+1  A result.
REQ-009 b_valid, b_ready, b_op1, b_op2, b_sel, b_rsp_valid, b_rsp_ready, b_rsp_data: same directions, widths and meanings for requester B.
REQ-010 dp_op1, dp_op2  output  DW  operands to the shared combinational datapath; dp_sel  output  2  datapath operation select.
REQ-011 dp_res  input  DW+1  combinational datapath result.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, EXEC, RESP.
REQ-014 IDLE, no valid: stay in IDLE; a_ready=b_ready=0.
REQ-015 IDLE, one valid: grant that requester; its ready=1 combinationally in the same cycle; latch its op1/op2/sel into dp_op1/dp_op2/dp_sel; record grant owner; next state EXEC.
REQ-016 IDLE, both valid: grant the requester not granted last (round-robin); after reset A has priority.
REQ-017 At most one of a_ready/b_ready is high in any cycle; both are 0 outside IDLE.
REQ-018 EXEC: one cycle for the datapath to settle; capture dp_res into the owner's rsp_data register at the end of EXEC; next state RESP.
REQ-019 RESP: owner's rsp_valid=1, rsp_data held stable, until owner's rsp_ready=1; in that cycle go to IDLE and update last-grant to owner.
REQ-020 Latency: accept at cycle N; dp_* outputs valid from N+1; rsp_valid from N+2; minimum 3 cycles per operation.
REQ-021 dp_op1/dp_op2/dp_sel hold their last latched values through EXEC, RESP and IDLE until the next accept.
REQ-022 rsp_ready from the non-owner, or from either requester outside RESP, is ignored.
REQ-023 Non-owner rsp_valid stays 0; non-owner rsp_data holds its previous value.
REQ-024 Requests arriving while busy are stalled (ready=0), never dropped; the requester keeps valid and operands stable until ready.
REQ-025 Result stored at full DW+1 width; no truncation or sign extension.
REQ-026 Round-robin starvation bound: with both valid continuously, each requester is granted at least once in every two operations.

Reset
REQ-027 rst=1 at a rising edge forces state IDLE, last-grant=B (so A wins first), busy=0, a_ready=b_ready=0, a_rsp_valid=b_rsp_valid=0, a_rsp_data=b_rsp_data=0, dp_op1=dp_op2=0, dp_sel=0.
REQ-028 Reset in EXEC or RESP aborts the operation; no rsp_valid is produced for it; the first cycle after reset release is IDLE.

Verification (bench stubs the datapath as dp_res = dp_op1 + dp_op2)
REQ-029 A alone: a_op1=FF, a_op2=FF, a_sel=00 -> a_ready at N; dp_op1=FF, dp_op2=FF at N+1; a_rsp_valid with a_rsp_data=1FE at N+2.
REQ-030 Simultaneous after reset: A(01,02), B(03,04) both valid -> A granted first (a_rsp_data=003), then B (b_rsp_data=007); no cycle with both readys high.
REQ-031 Continuous contention over 6 operations -> grants alternate A,B,A,B,A,B.
REQ-032 Backpressure: hold a_rsp_ready=0 for 5 cycles in RESP -> a_rsp_valid and a_rsp_data stay stable, busy=1, b_ready=0 throughout; release -> IDLE next cycle.
REQ-033 Reset in EXEC: assert rst one cycle -> all outputs at reset values, no rsp_valid; the subsequent B request completes normally.
REQ-034 Wrong-owner handshake: b_rsp_ready=1 while A's result is pending -> a_rsp_valid stays 1, state stays RESP.
